steer_step_scheduler: RTL and testbench



---
 rtl/steer_pkg.sv | 36 +++
 rtl/step_period_timer.sv | 58 +++++
 rtl/steer_step_scheduler.sv | 277 +++++++++++++++++++++++++++
 tb/tb_steer_step_scheduler.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/steer_pkg.sv
// Shared definitions for the steering stepper scheduler: state codes,
// default timing/travel constants, the signed position type and a clamp helper.
package steer_pkg;

    localparam int POS_W         = 8;
    localparam int DEF_LIMIT_POS = 75;
    localparam int DEF_TICK_FAST = 900_000;
    localparam int DEF_TICK_SLOW = 1_600_000;
    localparam int CNT_W         = 24;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_MANUAL = 3'd1;
    localparam state_t ST_CENTER = 3'd2;
    localparam state_t ST_TARGET = 3'd3;
    localparam state_t ST_SETTLE = 3'd4;

    typedef logic signed [POS_W-1:0] pos_t;

    // Limit a requested position to the symmetric travel window.
    function automatic pos_t clamp_pos(input pos_t v, input int lim);
        pos_t hi;
        pos_t lo;
        hi = pos_t'(lim);
        lo = pos_t'(-lim);
        if (v > hi) begin
            clamp_pos = hi;
        end else if (v < lo) begin
            clamp_pos = lo;
        end else begin
            clamp_pos = v;
        end
    endfunction

endpackage

// File: rtl/step_period_timer.sv
// Step period timer: free-running counter that fires a tick when the current
// period (base rate from engine_on, doubled while ramping) has elapsed.
// The terminal count is re-evaluated every cycle, so a shorter period that the
// counter has already passed fires on the very next cycle.
module step_period_timer
    import steer_pkg::*;
#(
    parameter int TICK_FAST = DEF_TICK_FAST,
    parameter int TICK_SLOW = DEF_TICK_SLOW
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic engine_on,
    input  logic ramp,
    output logic tick
);

    localparam logic [CNT_W-1:0] FAST_LAST      = CNT_W'(TICK_FAST - 1);
    localparam logic [CNT_W-1:0] FAST_RAMP_LAST = CNT_W'(2 * TICK_FAST - 1);
    localparam logic [CNT_W-1:0] SLOW_LAST      = CNT_W'(TICK_SLOW - 1);
    localparam logic [CNT_W-1:0] SLOW_RAMP_LAST = CNT_W'(2 * TICK_SLOW - 1);
    localparam logic [CNT_W-1:0] CNT_ONE        = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] last_s;

    // Select this cycle's terminal count and decide whether the period is up.
    always_comb begin
        last_s = SLOW_LAST;
        if (engine_on) begin
            if (ramp) begin
                last_s = FAST_RAMP_LAST;
            end else begin
                last_s = FAST_LAST;
            end
        end else begin
            if (ramp) begin
                last_s = SLOW_RAMP_LAST;
            end else begin
                last_s = SLOW_LAST;
            end
        end
        tick = (!clear) && (cnt_r >= last_s);
    end

    // Count clocks between steps; restart on clear or after each tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (clear || tick) begin
            cnt_r <= {CNT_W{1'b0}};
        end else begin
            cnt_r <= cnt_r + CNT_ONE;
        end
    end

endmodule

// File: rtl/steer_step_scheduler.sv
// Steering stepper scheduler: arbitrates manual keys, auto-center and the
// autopilot target, issues step pulses and owns the wheel position.
// Build option: define STEER_RAMP_EN to run the first RAMP_STEPS steps of
// every move at twice the base period; without it every step uses the base.
module steer_step_scheduler
    import steer_pkg::*;
#(
`ifdef STEER_RAMP_EN
    parameter int RAMP_STEPS = 4,
`endif
    parameter int TICK_FAST  = DEF_TICK_FAST,
    parameter int TICK_SLOW  = DEF_TICK_SLOW,
    parameter int LIMIT_POS  = DEF_LIMIT_POS,
    parameter int SETTLE_CYC = 250_000
) (
    input  logic clk,
    input  logic rst,
    input  logic engine_on,
    input  logic key_left,
    input  logic key_right,
    input  logic key_center,
    input  logic tgt_valid,
    input  pos_t tgt_pos,
    output logic tgt_ready,
    output logic tgt_done,
    output logic tgt_abort,
    output logic step_req,
    output logic step_dir,
    output pos_t pos,
    output logic busy,
    output logic at_limit
);

    localparam int   SC_W     = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [SC_W-1:0] SC_LAST = SC_W'(SETTLE_CYC - 1);
    localparam logic [SC_W-1:0] SC_ONE  = {{(SC_W-1){1'b0}}, 1'b1};
    localparam pos_t LIM_P    = pos_t'(LIMIT_POS);
    localparam pos_t LIM_N    = pos_t'(-LIMIT_POS);
    localparam pos_t POS_ZERO = {POS_W{1'b0}};
    localparam pos_t POS_ONE  = {{(POS_W-1){1'b0}}, 1'b1};

    state_t            state_r;
    state_t            state_nx_s;
    pos_t              pos_r;
    pos_t              pos_nx_s;
    pos_t              tgt_r;
    pos_t              tgt_nx_s;
    pos_t              tgt_clamp_s;
    logic              dir_r;
    logic              dir_nx_s;
    logic [SC_W-1:0]   settle_cnt_r;
    logic [SC_W-1:0]   settle_nx_s;
    logic              step_req_r;
    logic              step_dir_r;
    logic              tgt_done_r;
    logic              busy_r;
    logic              at_limit_r;

    logic              any_key_s;
    logic              manual_s;
    logic              ready_s;
    logic              abort_s;
    logic              done_nx_s;
    logic              moving_s;
    logic              move_dir_s;
    logic              room_s;
    logic              clear_s;
    logic              tick_s;
    logic              ramp_s;
    logic              step_s;

    // Key decoding and the combinational handshake outputs.
    always_comb begin
        any_key_s   = key_left | key_right | key_center;
        manual_s    = key_left ^ key_right;
        ready_s     = (!rst) && (state_r == ST_IDLE) && (!any_key_s);
        abort_s     = (!rst) && (state_r == ST_TARGET) && any_key_s;
        tgt_clamp_s = clamp_pos(tgt_pos, LIMIT_POS);
    end

    // Next-state arbitration: manual keys first, then target, then centering.
    always_comb begin
        state_nx_s = state_r;
        tgt_nx_s   = tgt_r;
        dir_nx_s   = dir_r;
        done_nx_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (manual_s) begin
                    state_nx_s = ST_MANUAL;
                    dir_nx_s   = key_left;
                end else if (tgt_valid && ready_s) begin
                    tgt_nx_s = tgt_clamp_s;
                    if (tgt_clamp_s == pos_r) begin
                        state_nx_s = ST_SETTLE;
                        done_nx_s  = 1'b1;
                    end else begin
                        state_nx_s = ST_TARGET;
                    end
                end else if (key_center && (pos_r != POS_ZERO)) begin
                    state_nx_s = ST_CENTER;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_MANUAL: begin
                if ((!manual_s) || (key_left != dir_r)) begin
                    state_nx_s = ST_SETTLE;
                end else begin
                    state_nx_s = ST_MANUAL;
                end
            end
            ST_CENTER: begin
                if ((pos_r == POS_ZERO) || (!key_center) || key_left || key_right) begin
                    state_nx_s = ST_SETTLE;
                end else begin
                    state_nx_s = ST_CENTER;
                end
            end
            ST_TARGET: begin
                if (any_key_s) begin
                    state_nx_s = ST_SETTLE;
                end else if (pos_r == tgt_r) begin
                    state_nx_s = ST_SETTLE;
                    done_nx_s  = 1'b1;
                end else begin
                    state_nx_s = ST_TARGET;
                end
            end
            ST_SETTLE: begin
                if (settle_cnt_r == SC_LAST) begin
                    state_nx_s = ST_IDLE;
                end else begin
                    state_nx_s = ST_SETTLE;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // Direction of travel for the moving states and whether the timer runs.
    always_comb begin
        moving_s   = 1'b0;
        move_dir_s = 1'b0;
        case (state_r)
            ST_MANUAL: begin
                moving_s   = 1'b1;
                move_dir_s = dir_r;
            end
            ST_CENTER: begin
                moving_s   = 1'b1;
                move_dir_s = (pos_r < POS_ZERO);
            end
            ST_TARGET: begin
                moving_s   = 1'b1;
                move_dir_s = (tgt_r > pos_r);
            end
            default: begin
                moving_s   = 1'b0;
                move_dir_s = 1'b0;
            end
        endcase
        clear_s = (!moving_s) || (state_nx_s != state_r);
    end

    // Issue a step only when the timer expires and the travel limit allows it.
    always_comb begin
        if (move_dir_s) begin
            room_s = (pos_r < LIM_P);
        end else begin
            room_s = (pos_r > LIM_N);
        end
        step_s = tick_s && room_s;
        if (step_s) begin
            if (move_dir_s) begin
                pos_nx_s = pos_r + POS_ONE;
            end else begin
                pos_nx_s = pos_r - POS_ONE;
            end
        end else begin
            pos_nx_s = pos_r;
        end
    end

    // Settle timer runs only while in SETTLE and restarts on every state entry.
    always_comb begin
        if (state_nx_s != state_r) begin
            settle_nx_s = {SC_W{1'b0}};
        end else if (state_r == ST_SETTLE) begin
            settle_nx_s = settle_cnt_r + SC_ONE;
        end else begin
            settle_nx_s = {SC_W{1'b0}};
        end
    end

`ifdef STEER_RAMP_EN
    localparam int RC_W = (RAMP_STEPS > 0) ? $clog2(RAMP_STEPS + 1) : 1;
    localparam logic [RC_W-1:0] RAMP_LIM = RC_W'(RAMP_STEPS);
    localparam logic [RC_W-1:0] RC_ONE   = {{(RC_W-1){1'b0}}, 1'b1};

    logic [RC_W-1:0] ramp_cnt_r;

    // Ramp is active until RAMP_STEPS steps of the current move have been issued.
    always_comb begin
        ramp_s = (ramp_cnt_r < RAMP_LIM);
    end

    // Count issued steps per move, saturating at the ramp length.
    always_ff @(posedge clk) begin
        if (rst) begin
            ramp_cnt_r <= {RC_W{1'b0}};
        end else if (state_nx_s != state_r) begin
            ramp_cnt_r <= {RC_W{1'b0}};
        end else if (step_s && ramp_s) begin
            ramp_cnt_r <= ramp_cnt_r + RC_ONE;
        end else begin
            ramp_cnt_r <= ramp_cnt_r;
        end
    end
`else
    // Without the ramp option every step uses the base period.
    always_comb begin
        ramp_s = 1'b0;
    end
`endif

    step_period_timer #(
        .TICK_FAST (TICK_FAST),
        .TICK_SLOW (TICK_SLOW)
    ) u_timer (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear_s),
        .engine_on (engine_on),
        .ramp      (ramp_s),
        .tick      (tick_s)
    );

    // State, position and registered outputs; flags follow next-state values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            pos_r        <= POS_ZERO;
            tgt_r        <= POS_ZERO;
            dir_r        <= 1'b0;
            settle_cnt_r <= {SC_W{1'b0}};
            step_req_r   <= 1'b0;
            step_dir_r   <= 1'b0;
            tgt_done_r   <= 1'b0;
            busy_r       <= 1'b0;
            at_limit_r   <= 1'b0;
        end else begin
            state_r      <= state_nx_s;
            pos_r        <= pos_nx_s;
            tgt_r        <= tgt_nx_s;
            dir_r        <= dir_nx_s;
            settle_cnt_r <= settle_nx_s;
            step_req_r   <= step_s;
            step_dir_r   <= step_s ? move_dir_s : step_dir_r;
            tgt_done_r   <= done_nx_s;
            busy_r       <= (state_nx_s != ST_IDLE);
            at_limit_r   <= (pos_nx_s == LIM_P) || (pos_nx_s == LIM_N);
        end
    end

    assign tgt_ready = ready_s;
    assign tgt_abort = abort_s;
    assign tgt_done  = tgt_done_r;
    assign step_req  = step_req_r;
    assign step_dir  = step_dir_r;
    assign pos       = pos_r;
    assign busy      = busy_r;
    assign at_limit  = at_limit_r;

endmodule

// File: tb/tb_steer_step_scheduler.sv
// Scoreboard bench for steer_step_scheduler: a behavioural model predicts
// per-cycle status and output events; a monitor compares them with the DUT.
module tb_steer_step_scheduler;

    localparam int TF  = 10;
    localparam int TS  = 20;
    localparam int RS  = 2;
    localparam int SC  = 5;
    localparam int LIM = 3;
`ifdef STEER_RAMP_EN
    localparam bit RAMP_ON = 1'b1;
`else
    localparam bit RAMP_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic engine_on = 1'b1;
    logic key_left = 1'b0;
    logic key_right = 1'b0;
    logic key_center = 1'b0;
    logic tgt_valid = 1'b0;
    logic signed [7:0] tgt_pos = 8'sd0;
    logic tgt_ready, tgt_done, tgt_abort, step_req, step_dir, busy, at_limit;
    logic signed [7:0] pos;

    always #5 clk = ~clk;

    steer_step_scheduler #(
`ifdef STEER_RAMP_EN
        .RAMP_STEPS (RS),
`endif
        .TICK_FAST  (TF),
        .TICK_SLOW  (TS),
        .LIMIT_POS  (LIM),
        .SETTLE_CYC (SC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .engine_on  (engine_on),
        .key_left   (key_left),
        .key_right  (key_right),
        .key_center (key_center),
        .tgt_valid  (tgt_valid),
        .tgt_pos    (tgt_pos),
        .tgt_ready  (tgt_ready),
        .tgt_done   (tgt_done),
        .tgt_abort  (tgt_abort),
        .step_req   (step_req),
        .step_dir   (step_dir),
        .pos        (pos),
        .busy       (busy),
        .at_limit   (at_limit)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int fails  = 0;

    function automatic void check(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endfunction

    function automatic int iabs(int v);
        return (v < 0) ? -v : v;
    endfunction

    typedef struct {
        int cyc;
        bit step;
        bit dir;
        bit done;
        bit abort;
    } ev_t;

    typedef struct {
        int pos;
        bit busy;
        bit lim;
        bit ready;
    } st_t;

    ev_t evq[$];
    st_t stq[$];

    // ---------------- behavioural model ----------------
    string m_mode = "idle";
    int m_pos = 0, m_tgt = 0, m_dir = 1, m_elapsed = 0, m_steps = 0, m_settle_left = 0;
    int m_stepdir = 0;
    bit m_step = 1'b0, m_done = 1'b0;

    task automatic enter(string mode);
        m_mode = mode;
        m_elapsed = 0;
        m_steps = 0;
        m_settle_left = SC;
    endtask

    task automatic model_cycle();
        bit any, ready, abort, manual;
        int goal, period;
        any    = key_left | key_right | key_center;
        manual = (key_left != key_right);
        ready  = !rst && (m_mode == "idle") && !any;
        abort  = !rst && (m_mode == "target") && any;
        if (m_step || m_done || abort)
            evq.push_back('{cyc, m_step, (m_stepdir > 0), m_done, abort});
        stq.push_back('{m_pos, (m_mode != "idle"), (iabs(m_pos) == LIM), ready});
        m_step = 1'b0;
        m_done = 1'b0;
        if (rst) begin
            enter("idle");
            m_pos = 0;
        end else if (m_mode == "idle") begin
            if (manual) begin
                enter("manual");
                m_dir = key_left ? 1 : -1;
            end else if (tgt_valid && ready) begin
                m_tgt = int'(tgt_pos);
                if (m_tgt > LIM) m_tgt = LIM;
                if (m_tgt < -LIM) m_tgt = -LIM;
                if (m_tgt == m_pos) begin
                    enter("settle");
                    m_done = 1'b1;
                end else begin
                    enter("target");
                end
            end else if (key_center && m_pos != 0) begin
                enter("center");
            end
        end else if (m_mode == "settle") begin
            if (m_settle_left <= 1) enter("idle");
            else m_settle_left--;
        end else begin
            bit leave;
            leave = 1'b0;
            if (m_mode == "manual") begin
                leave = !manual || ((key_left ? 1 : -1) != m_dir);
                goal  = m_dir;
            end else if (m_mode == "center") begin
                leave = (m_pos == 0) || !key_center || key_left || key_right;
                goal  = (m_pos < 0) ? 1 : -1;
            end else begin
                leave = abort || (m_pos == m_tgt);
                if (!abort && m_pos == m_tgt) m_done = 1'b1;
                goal  = (m_tgt > m_pos) ? 1 : -1;
            end
            if (leave) begin
                enter("settle");
            end else begin
                period = (engine_on ? TF : TS) * ((RAMP_ON && m_steps < RS) ? 2 : 1);
                if (m_elapsed + 1 >= period) begin
                    m_elapsed = 0;
                    if (iabs(m_pos + goal) <= LIM) begin
                        m_pos += goal;
                        m_step = 1'b1;
                        m_stepdir = goal;
                        m_steps++;
                    end
                end else begin
                    m_elapsed++;
                end
            end
        end
    endtask

    initial forever begin
        @(negedge clk);
        model_cycle();
    end

    // ---------------- monitor ----------------
    initial forever begin
        st_t s;
        ev_t e;
        @(negedge clk);
        #1;
        if (stq.size() > 0) begin
            s = stq.pop_front();
            check("pos", int'(pos), s.pos);
            check("busy", int'(busy), int'(s.busy));
            check("at_limit", int'(at_limit), int'(s.lim));
            check("tgt_ready", int'(tgt_ready), int'(s.ready));
        end
        if (evq.size() > 0 && evq[0].cyc < cyc) begin
            e = evq.pop_front();
            check("missed_event_cycle", cyc, e.cyc);
        end
        if (step_req || tgt_done || tgt_abort) begin
            if (evq.size() == 0) begin
                check("unexpected_event", 1, 0);
            end else begin
                e = evq.pop_front();
                check("event_cycle", cyc, e.cyc);
                check("step_req", int'(step_req), int'(e.step));
                check("tgt_done", int'(tgt_done), int'(e.done));
                check("tgt_abort", int'(tgt_abort), int'(e.abort));
                if (e.step) check("step_dir", int'(step_dir), int'(e.dir));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(bit l, bit r, bit c, bit tv, int tp, bit eng, int n, bit jitter);
        key_left   = l;
        key_right  = r;
        key_center = c;
        tgt_valid  = tv;
        tgt_pos    = 8'(tp);
        engine_on  = eng;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (jitter && $urandom_range(0, 29) == 0) engine_on = ~engine_on;
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        // hold left to the limit with power steering
        drive(1, 0, 0, 0, 0, 1, 120, 0);
        drive(0, 0, 0, 0, 0, 1, 20, 0);
        // clamped target across the full range, engine off
        drive(0, 0, 0, 1, -5, 0, 1, 0);
        drive(0, 0, 0, 0, 0, 0, 250, 0);
        // target move preempted by a key
        drive(0, 0, 0, 1, 3, 1, 1, 0);
        drive(0, 0, 0, 0, 0, 1, 25, 0);
        drive(0, 1, 0, 0, 0, 1, 3, 0);
        drive(0, 0, 0, 0, 0, 1, 30, 0);
        // both keys: no request
        drive(1, 1, 0, 0, 0, 1, 100, 0);
        drive(0, 0, 0, 0, 0, 1, 10, 0);
        // return to center, then a target equal to the current position
        drive(0, 0, 1, 0, 0, 1, 200, 0);
        drive(0, 0, 0, 0, 0, 1, 10, 0);
        drive(0, 0, 0, 1, m_pos, 1, 1, 0);
        drive(0, 0, 0, 0, 0, 1, 10, 0);
        // reset in the middle of a manual move
        drive(0, 1, 0, 0, 0, 1, 17, 0);
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 1, 1, 0);
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 1, 40, 0);
        // randomized phases
        for (int p = 0; p < 160; p++) begin
            int kind, dur, tp;
            bit eng;
            kind = int'($urandom_range(0, 8));
            dur  = int'($urandom_range(1, 120));
            tp   = int'($urandom_range(0, 12)) - 6;
            eng  = bit'($urandom_range(0, 1));
            case (kind)
                0: drive(0, 0, 0, 0, 0, eng, dur, 1);
                1: drive(1, 0, 0, 0, 0, eng, dur, 1);
                2: drive(0, 1, 0, 0, 0, eng, dur, 1);
                3: drive(1, 1, 0, 0, 0, eng, dur, 1);
                4: drive(0, 0, 1, 0, 0, eng, dur, 1);
                5: drive(0, 0, 0, 1, tp, eng, dur, 1);
                6: drive(0, 0, 0, 1, tp, eng, 1, 0);
                7: drive(1, 0, 1, 0, 0, eng, dur, 1);
                default: begin
                    rst = 1'b1;
                    drive(0, 0, 0, 0, 0, eng, int'($urandom_range(1, 3)), 0);
                    rst = 1'b0;
                end
            endcase
        end
        drive(0, 0, 0, 0, 0, 1, 300, 0);
        check("pending_events", evq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
